// File: rtl/traceback_ctrl_pkg.sv
// traceback_ctrl_pkg: shared FSM encoding, trellis state width and predecessor helper
package traceback_ctrl_pkg;
  localparam int ST_W = 2;
  typedef enum logic [2:0] {COLLECT, LATCH, TRACE, EMIT, CLEAR} fsm_t;
  function automatic logic [ST_W-1:0] pred_state(input logic [ST_W-1:0] n, input logic [2**ST_W-1:0] dec);
    return {n[0], dec[n]};
  endfunction
endpackage

// File: rtl/traceback_ctrl_tb_mem.sv
// tb_mem: survivor decision memory plus decoded-bit buffer, shared write/read addresses, combinational read
module tb_mem #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     dec_we,
  input  logic                     bit_we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic [3:0]               wdec,
  input  logic                     wbit,
  output logic [3:0]               rdec,
  output logic                     rbit
);
  logic [3:0] dec_mem [DEPTH];
  logic       bit_mem [DEPTH];
  // write decisions while collecting and decoded bits while tracing
  always_ff @(posedge clk) begin
    if (dec_we) dec_mem[waddr] <= wdec;
    if (bit_we) bit_mem[waddr] <= wbit;
  end
  assign rdec = dec_mem[raddr];
  assign rbit = bit_mem[raddr];
endmodule

// File: rtl/traceback_ctrl.sv
// traceback_ctrl: collects ACS decisions per frame, traces back from the best state and emits bits in order
module traceback_ctrl
  import traceback_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [3:0]      in_dec,
  input  logic            in_last,
  output logic            in_ready,
  input  logic [ST_W-1:0] min_state,
  output logic            acs_en,
  output logic            acs_clr,
  output logic            out_valid,
  output logic            out_bit,
  output logic            out_last,
  input  logic            out_ready,
  output logic            ovf
);
  localparam int AW = $clog2(DEPTH);
  fsm_t            state, nxt;
  logic [AW-1:0]   wr_ptr, idx;
  logic [AW:0]     len;
  logic [ST_W-1:0] n;
  logic [3:0]      rdec;
  logic            rbit, full, last_out, tracing;
  assign full     = wr_ptr == AW'(DEPTH - 1);
  assign last_out = {1'b0, idx} == len - 1'b1;
  assign tracing  = state == TRACE;
  // state register
  always_ff @(posedge clk) state <= rst ? COLLECT : nxt;
  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      COLLECT: nxt = acs_en && (in_last || full) ? LATCH : COLLECT;
      LATCH:   nxt = TRACE;
      TRACE:   nxt = idx == '0 ? EMIT : TRACE;
      EMIT:    nxt = out_ready && last_out ? CLEAR : EMIT;
      CLEAR:   nxt = COLLECT;
      default: nxt = COLLECT;
    endcase
  end
  // outputs, forced quiet while reset is held
  always_comb begin
    in_ready  = !rst && state == COLLECT;
    acs_en    = in_ready && in_valid;
    acs_clr   = !rst && state == CLEAR;
    out_valid = !rst && state == EMIT;
    out_bit   = out_valid && rbit;
    out_last  = out_valid && last_out;
  end
  // frame bookkeeping: write pointer, length, trace index and current trellis state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      len    <= '0;
      idx    <= '0;
      n      <= '0;
      ovf    <= 1'b0;
    end else begin
      if (acs_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        len    <= {1'b0, wr_ptr} + 1'b1;
        ovf    <= ovf | (full & ~in_last);
      end
      if (state == LATCH) begin
        n   <= min_state;
        idx <= AW'(len - 1'b1);
      end
      if (tracing) begin
        n   <= pred_state(n, rdec);
        idx <= idx == '0 ? '0 : idx - 1'b1;
      end
      if (out_valid && out_ready) idx <= idx + 1'b1;
      if (state == CLEAR) wr_ptr <= '0;
    end
  end
  tb_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .dec_we(acs_en),
    .bit_we(tracing),
    .waddr (tracing ? idx : wr_ptr),
    .raddr (idx),
    .wdec  (in_dec),
    .wbit  (n[1]),
    .rdec  (rdec),
    .rbit  (rbit)
  );
endmodule

// File: tb/tb_traceback_ctrl.sv
// tb_traceback_ctrl: directed and randomized frames checked against an array-based traceback model
module tb_traceback_ctrl;
  localparam int DEPTH = 16;
  logic       clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic [3:0] in_dec = 0;
  logic [1:0] min_state = 0;
  logic       in_ready, acs_en, acs_clr, out_valid, out_bit, out_last, ovf;
  int         checks = 0, errors = 0, acs_cnt = 0, clr_cnt = 0;
  logic [3:0] fd [DEPTH];
  logic       eb [DEPTH];
  bit         exp_ovf = 0;
  int         pat [4] = '{1, 0, 0, 1};

  traceback_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_dec(in_dec), .in_last(in_last),
    .in_ready(in_ready), .min_state(min_state), .acs_en(acs_en), .acs_clr(acs_clr),
    .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last), .out_ready(out_ready),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (acs_en) acs_cnt <= acs_cnt + 1;
    if (acs_clr) clr_cnt <= clr_cnt + 1;
  end

  task automatic check(string tag, int obs, int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(int len, logic [1:0] ms);
    logic [1:0] s = ms;
    for (int i = len - 1; i >= 0; i--) begin
      eb[i] = s[1];
      s = {s[0], fd[i][s]};
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; out_ready = 0;
    @(negedge clk);
    rst = 0;
    exp_ovf = 0;
    #1 check("reset_ovf", ovf, 0);
  endtask

  task automatic send(int len, bit last, logic [1:0] ms);
    int a0 = acs_cnt;
    min_state = ms;
    for (int i = 0; i < len; i++) begin
      if ($urandom % 4 == 0) begin
        @(negedge clk);
        in_valid = 0;
        #1 check("idle_acs_en", acs_en, 0);
      end
      @(negedge clk);
      check("collect_in_ready", in_ready, 1);
      in_valid = 1; in_dec = fd[i]; in_last = last && i == len - 1;
      #1 check("acs_en", acs_en, 1);
    end
    @(negedge clk);
    in_valid = 0; in_last = 0; in_dec = 4'($urandom);
    check("latch_in_ready", in_ready, 0);
    check("acs_count", acs_cnt - a0, len);
    if (!last) exp_ovf = 1;
    check("ovf", ovf, exp_ovf);
  endtask

  task automatic recv(int len, int mode, int abort_at);
    int  k = 0, budget = 4 * DEPTH + 40, p = 0, c0 = clr_cnt;
    bit  rdy;
    while (k < len && budget > 0) begin
      @(negedge clk);
      budget--;
      check("busy_in_ready", in_ready, 0);
      if (out_valid) begin
        check("out_bit", out_bit, eb[k]);
        check("out_last", out_last, k == len - 1);
        if (k == abort_at) begin
          rst = 1; out_ready = 0; in_valid = 0;
          @(negedge clk);
          rst = 0; exp_ovf = 0;
          #1 check("abort_out_valid", out_valid, 0);
          check("abort_in_ready", in_ready, 1);
          return;
        end
        rdy = mode == 0 ? 1'b1 : mode == 1 ? pat[p % 4] == 1 : 1'($urandom);
        p++;
        out_ready = rdy;
        if (rdy) k++;
      end else out_ready = 1'($urandom);
      in_valid = 1'($urandom);
      #1 check("busy_acs_en", acs_en, 0);
    end
    if (k < len) check("emit_timeout", k, len);
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    check("clear_pulse", acs_clr, 1);
    check("clear_out_valid", out_valid, 0);
    @(negedge clk);
    check("post_in_ready", in_ready, 1);
    check("post_acs_clr", acs_clr, 0);
    check("clr_count", clr_cnt - c0, 1);
  endtask

  initial begin
    int len;
    bit ovfl;
    logic [1:0] ms;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_acs_en", acs_en, 0);
    check("rst_acs_clr", acs_clr, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_last", out_last, 0);
    rst = 0;
    #1 check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin fd[i] = 4'b0000; eb[i] = 0; end
    send(8, 1, 2'b00);
    recv(8, 0, -1);

    fd[0] = 4'b0000; fd[1] = 4'b0000; fd[2] = 4'b0100; fd[3] = 4'b0000;
    eb[0] = 1; eb[1] = 0; eb[2] = 1; eb[3] = 1;
    send(4, 1, 2'b11);
    recv(4, 0, -1);

    for (int i = 0; i < 6; i++) fd[i] = 4'($urandom);
    model(6, 2'b01);
    send(6, 1, 2'b01);
    recv(6, 1, -1);

    for (int i = 0; i < DEPTH; i++) fd[i] = 4'($urandom);
    model(DEPTH, 2'b10);
    send(DEPTH, 0, 2'b10);
    recv(DEPTH, 2, -1);
    check("ovf_sticky", ovf, 1);
    do_reset();

    fd[0] = 4'b0000; eb[0] = 1;
    send(1, 1, 2'b10);
    recv(1, 0, -1);

    for (int i = 0; i < 6; i++) fd[i] = 4'($urandom);
    model(6, 2'b11);
    send(6, 1, 2'b11);
    recv(6, 0, 2);
    for (int i = 0; i < 5; i++) fd[i] = 4'($urandom);
    model(5, 2'b01);
    send(5, 1, 2'b01);
    recv(5, 0, -1);

    for (int f = 0; f < 20; f++) begin
      ovfl = $urandom % 5 == 0;
      len = ovfl ? DEPTH : 1 + int'($urandom % DEPTH);
      ms = 2'($urandom);
      for (int i = 0; i < len; i++) fd[i] = 4'($urandom);
      model(len, ms);
      send(len, !ovfl, ms);
      recv(len, 2, -1);
      check("frame_ovf", ovf, exp_ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
